mem_port_arbiter: RTL

Shares one single-ported memory bus between instruction fetch (IF) and data access (MEM) in the 5-stage RV32I pipeline. Grants one request at a time, with fixed priority to MEM because it is the older instruction. Drives registered bus signals and returns read data with one-cycle done pulses. Produces per-stage stall levels for the hazard unit, supports dropping a fetch on branch flush, and aborts any transfer with no ack after a timeout.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-bus signal bundle for mem_port_arbiter.
// master = the arbiter itself; slave = the pipeline stages and memory around it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;

    logic              bus_err;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [STRB_W-1:0] bus_wstrb;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  bus_ack, bus_rdata,
        output if_done, if_rdata, if_stall,
        output mem_done, mem_rdata, mem_stall,
        output bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
    );

    modport slave (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output bus_ack, bus_rdata,
        input  if_done, if_rdata, if_stall,
        input  mem_done, mem_rdata, mem_stall,
        input  bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data access,
// data access first; registered bus outputs, done pulses, flush drop and ack timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.master    port
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_drop;
    logic              r_if_done;
    logic              r_mem_done;
    logic              r_bus_err;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [STRB_W-1:0] r_bus_wstrb;

    logic w_mem_go;
    logic w_if_go;
    logic w_timeout;
    logic w_drop;

    // A requester whose done pulse is high this cycle has not yet seen it, so it is masked.
    assign w_mem_go  = port.mem_req & ~r_mem_done;
    assign w_if_go   = port.if_req & ~port.if_flush & ~r_if_done;
    assign w_timeout = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1)) && !port.bus_ack;
    assign w_drop    = r_drop | port.if_flush;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every branch reads pre-edge state; defaults below are legal overrides.
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_drop      <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_mem_go) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= port.mem_we;
                        r_bus_addr  <= port.mem_addr;
                        r_bus_wdata <= port.mem_wdata;
                        r_bus_wstrb <= port.mem_we ? port.mem_wstrb : '0;
                        r_state     <= DATA;
                    end else if (w_if_go) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= port.if_addr;
                        r_bus_wstrb <= '0;
                        r_drop      <= 1'b0;
                        r_state     <= FETCH;
                    end
                end
                DATA: begin
                    if (port.bus_ack) begin
                        r_bus_req  <= 1'b0;
                        r_cnt      <= '0;
                        r_mem_done <= 1'b1;
                        if (!r_bus_we) r_mem_rdata <= port.bus_rdata;
                        r_state    <= IDLE;
                    end else if (w_timeout) begin
                        r_bus_req  <= 1'b0;
                        r_cnt      <= '0;
                        r_mem_done <= 1'b1;
                        r_bus_err  <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FETCH: begin
                    if (port.if_flush) r_drop <= 1'b1;
                    if (port.bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_cnt     <= '0;
                        r_drop    <= 1'b0;
                        if (!w_drop) begin
                            r_if_rdata <= port.bus_rdata;
                            r_if_done  <= 1'b1;
                        end
                        r_state   <= IDLE;
                    end else if (w_timeout) begin
                        // A flushed fetch has no owner left to notify; the error still reports.
                        r_bus_req <= 1'b0;
                        r_cnt     <= '0;
                        r_drop    <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!w_drop) r_if_done <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign port.if_done   = r_if_done;
    assign port.if_rdata  = r_if_rdata;
    assign port.if_stall  = port.if_req & ~r_if_done & ~port.if_flush;
    assign port.mem_done  = r_mem_done;
    assign port.mem_rdata = r_mem_rdata;
    assign port.mem_stall = port.mem_req & ~r_mem_done;
    assign port.bus_err   = r_bus_err;
    assign port.bus_req   = r_bus_req;
    assign port.bus_we    = r_bus_we;
    assign port.bus_addr  = r_bus_addr;
    assign port.bus_wdata = r_bus_wdata;
    assign port.bus_wstrb = r_bus_wstrb;
endmodule
